mp_add_stream: RTL and testbench

Sequential multi-precision adder that streams operand word pairs over an AXI-Stream-style interface and feeds each pair, with the correct carry-in, into one WIDTH-bit `sqrt_csla` carry-select adder instance. Wide operands (N×WIDTH bits) arrive least-significant word first as a packet. The carry is chained across beats inside the block. Sum words leave through a 2-entry output buffer with full backpressure support. The block sits directly upstream of the adder core and owns all carry sequencing.

---
 rtl/mp_add_stream.sv | 161 ++++++++++++++++
 tb/tb_mp_add_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_stream.sv
// mp_add_stream: streaming multi-precision adder.
// Operand word pairs {b, a} arrive least-significant word first. Each accepted
// beat is added with the chained carry (or the packet carry-in on the first
// beat) in one WIDTH-bit square-root carry-select adder. Sum words leave
// through a 2-entry output FIFO with full backpressure.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_axis_tdata [2*WIDTH-1:0]    operand pair {b, a}
//   s_axis_tvalid/tready/tlast    input handshake, tlast = most-significant word
//   s_axis_tuser                  carry-in for the first beat of a packet
//   m_axis_tdata [WIDTH-1:0]      sum word
//   m_axis_tvalid/tready/tlast    output handshake, tlast copied from input
//   m_axis_tuser                  carry-out on the last beat, else 0
//   pkt_count [15:0]              packets fully delivered, wrapping

// sqrt_csla: carry-select adder with block sizes 2,2,3,4,5,... (clipped to WIDTH).
// Ports: a_i, b_i operands; cin_i carry-in; sum_o sum; cout_o carry-out.
module sqrt_csla #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    function automatic int blk_lo(input int k);
        int lo;
        lo = 0;
        for (int j = 0; j < k; j++) lo += (j < 2) ? 2 : j + 1;
        return lo;
    endfunction

    function automatic int num_blk();
        int k;
        k = 0;
        while (blk_lo(k) < WIDTH) k++;
        return k;
    endfunction

    localparam int NBLK = num_blk();

    logic [NBLK:0] c;
    assign c[0] = cin_i;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        localparam int LO  = blk_lo(k);
        localparam int HI0 = blk_lo(k + 1);
        localparam int HI  = (HI0 > WIDTH) ? WIDTH : HI0;
        localparam int BW  = HI - LO;

        // Both carry hypotheses are precomputed; the incoming carry only selects.
        logic [BW:0] s0, s1;
        assign s0 = {1'b0, a_i[HI-1:LO]} + {1'b0, b_i[HI-1:LO]};
        assign s1 = {1'b0, a_i[HI-1:LO]} + {1'b0, b_i[HI-1:LO]} + (BW + 1)'(1);
        assign sum_o[HI-1:LO] = c[k] ? s1[BW-1:0] : s0[BW-1:0];
        assign c[k+1]         = c[k] ? s1[BW] : s0[BW];
    end

    assign cout_o = c[NBLK];
endmodule

module mp_add_stream #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tuser,
    output logic [WIDTH-1:0]   m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic [15:0]        pkt_count
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             last;
        logic             user;
    } ent_t;

    ent_t        ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0]  count_q, count_d;
    logic        carry_q, carry_d;
    logic        first_q, first_d;
    logic [15:0] pkt_q, pkt_d;

    logic             push, pop, cin, cout;
    logic [WIDTH-1:0] sum;

    assign cin = first_q ? s_axis_tuser : carry_q;

    sqrt_csla #(.WIDTH(WIDTH)) u_add (
        .a_i   (s_axis_tdata[WIDTH-1:0]),
        .b_i   (s_axis_tdata[2*WIDTH-1:WIDTH]),
        .cin_i (cin),
        .sum_o (sum),
        .cout_o(cout)
    );

    assign s_axis_tready = (count_q != 2'd2) & ~rst;
    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = ent0_q.sum;
    assign m_axis_tlast  = ent0_q.last;
    assign m_axis_tuser  = ent0_q.user;
    assign pkt_count     = pkt_q;

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    always_comb begin
        new_ent.sum  = sum;
        new_ent.last = s_axis_tlast;
        new_ent.user = s_axis_tlast & cout;
    end

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        carry_d = carry_q;
        first_d = first_q;
        pkt_d   = pkt_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        if (pop) begin
            ent0_d = ent1_q;
            if (ent0_q.last) pkt_d = pkt_q + 16'd1;
        end

        if (push) begin
            // Push with pop implies count was 1, so the new word becomes the head.
            if (count_q == 2'd0 || pop) ent0_d = new_ent;
            else                        ent1_d = new_ent;
            carry_d = s_axis_tlast ? 1'b0 : cout;
            first_d = s_axis_tlast;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
            carry_q <= 1'b0;
            first_q <= 1'b1;
            pkt_q   <= 16'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            carry_q <= carry_d;
            first_q <= first_d;
            pkt_q   <= pkt_d;
        end
    end
endmodule

// File: tb/tb_mp_add_stream.sv
module tb_mp_add_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [15:0] m_tdata;
    logic        m_tvalid, m_ready, m_tlast, m_tuser;
    logic [15:0] pkt_count;

    mp_add_stream #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_ready),
        .m_axis_tlast (m_tlast),
        .m_axis_tuser (m_tuser),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        u;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_pkt = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
    bit   bp_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready driver
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) if (s_tvalid && s_tready) acc_cnt++;

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_tvalid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %0h with no expected entry", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", {16'd0, m_tdata}, {16'd0, e.d});
                    chk("tlast", {31'd0, m_tlast}, {31'd0, e.l});
                    chk("tuser", {31'd0, m_tuser}, {31'd0, e.u});
                    chk("pkt_count_run", {16'd0, pkt_count}, exp_pkt);
                    if (e.l) exp_pkt++;
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic last, input logic user, input exp_t e);
        s_tdata  = {b, a};
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_tready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                s_tvalid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: got tready=0 for 300 cycles expected accept");
        s_tvalid = 1'b0;
    endtask

    // Whole-operand reference: A + B + cin computed as one wide integer.
    task automatic send_pkt(input int n, input logic [63:0] a_in, input logic [63:0] b_in,
                            input logic cin);
        logic [64:0] mask, tot;
        exp_t e;
        mask = (65'd1 << (16 * n)) - 65'd1;
        tot  = ({1'b0, a_in} & mask) + ({1'b0, b_in} & mask) + {64'd0, cin};
        for (int i = 0; i < n; i++) begin
            e.d = tot[16*i +: 16];
            e.l = (i == n - 1);
            e.u = (i == n - 1) ? tot[16*n] : 1'b0;
            send_beat(a_in[16*i +: 16], b_in[16*i +: 16], e.l, cin, e);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   acc0;
        logic [63:0] ra, rb;
        int   n;

        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tready", {31'd0, s_tready}, 0);
        chk("rst_tvalid", {31'd0, m_tvalid}, 0);
        chk("rst_tdata", {16'd0, m_tdata}, 0);
        chk("rst_tlast_tuser", {30'd0, m_tlast, m_tuser}, 0);
        chk("rst_pkt", {16'd0, pkt_count}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_rst", {31'd0, s_tready}, 1);

        // Single-beat packet with latency check
        rdy_mode = 1;
        @(posedge clk); #1;
        send_pkt(1, 64'hFFFF, 64'h0001, 1'b0);
        chk("lat_tvalid", {31'd0, m_tvalid}, 1);
        chk("lat_tdata", {16'd0, m_tdata}, 32'h0);
        chk("lat_last_user", {30'd0, m_tlast, m_tuser}, 32'h3);
        @(posedge clk); #1;
        chk("pkt_after_first", {16'd0, pkt_count}, 1);

        // 48-bit add, carry-in, carry isolation
        send_pkt(3, 64'h0001_FFFF_FFFF, 64'h0000_0000_0001, 1'b0);
        send_pkt(1, 64'h1234, 64'h0000, 1'b1);
        send_pkt(1, 64'hFFFF, 64'h0001, 1'b0);
        send_pkt(1, 64'h0000, 64'h0000, 1'b0);
        drain();

        // Backpressure: 5 back-to-back beats, ready held low 4 cycles
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        acc0 = acc_cnt;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_pkt(1, 64'(16'h1000 + i * 16'h0111), 64'(16'h0F00 + i), 1'(i & 1));
                bp_done = 1'b1;
            end
        join_none
        repeat (4) @(posedge clk); #1;
        chk("bp_accepted", acc_cnt - acc0, 2);
        chk("bp_tready_low", {31'd0, s_tready}, 0);
        chk("bp_tvalid_held", {31'd0, m_tvalid}, 1);
        rdy_mode = 1;
        for (int t = 0; t < 200 && !bp_done; t++) @(posedge clk);
        if (!bp_done) begin
            total++;
            bad++;
            $display("FAIL bp_sender_timeout: got done=0 expected 1");
        end
        #1;
        drain();

        // Reset mid-packet with carry pending
        rdy_mode = 0;
        @(posedge clk); #1;
        e.d = 16'h0000; e.l = 1'b0; e.u = 1'b0;
        send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, e);
        send_beat(16'hFFFF, 16'h0000, 1'b0, 1'b0, e);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", {31'd0, m_tvalid}, 0);
        chk("midrst_pkt", {16'd0, pkt_count}, 0);
        exp_q.delete();
        exp_pkt = 0;
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 1;
        @(posedge clk); #1;
        send_pkt(1, 64'h0000, 64'h0000, 1'b0);
        drain();
        chk("pkt_after_midrst", {16'd0, pkt_count}, 1);

        // Randomized packets with random downstream ready
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            n  = $urandom_range(1, 3);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (p % 5 == 0) rb = ~ra;
            send_pkt(n, ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        rdy_mode = 1;
        drain();
        chk("pkt_final", {16'd0, pkt_count}, exp_pkt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
